// File: rtl/ahb2irqc_pkg.sv
// Shared constants for the AHB-Lite interrupt controller: bus width,
// claim ID width and the word offsets of the register map.
package ahb2irqc_pkg;

    localparam int AHB_DW    = 32;
    localparam int IRQC_ID_W = 5;

    localparam logic [2:0] IRQC_PENDING = 3'd0;
    localparam logic [2:0] IRQC_ENABLE  = 3'd1;
    localparam logic [2:0] IRQC_EDGE    = 3'd2;
    localparam logic [2:0] IRQC_CLAIM   = 3'd3;
    localparam logic [2:0] IRQC_SET     = 3'd4;

    // An address phase is only real when the slave is selected, the bus is
    // ready and the transfer is NONSEQ or SEQ.
    function automatic logic isValidXfer(input logic hsel, input logic hready,
                                         input logic [1:0] htrans);
        return hsel & hready & htrans[1];
    endfunction

endpackage

// File: rtl/ahb2irqc_if.sv
// AHB-Lite slave-side signal bundle used between the bus fabric and the
// interrupt controller.
interface ahb2irqc_if;
    import ahb2irqc_pkg::*;

    logic              HSEL;
    logic              HREADY;
    logic [AHB_DW-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [AHB_DW-1:0] HWDATA;
    logic [AHB_DW-1:0] HRDATA;
    logic              HREADYOUT;

    modport master (
        output HSEL, HREADY, HADDR, HTRANS, HWRITE, HWDATA,
        input  HRDATA, HREADYOUT
    );

    modport slave (
        input  HSEL, HREADY, HADDR, HTRANS, HWRITE, HWDATA,
        output HRDATA, HREADYOUT
    );

endinterface

// File: rtl/ahb2irqc_prio_enc.sv
// Fixed-priority encoder: the lowest set request wins. Returns its index
// plus one (0 means nothing requested) and a one-hot mask of the winner.
module irqc_prio_enc
    import ahb2irqc_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0]   i_req,
    output logic [IRQC_ID_W-1:0] o_id,
    output logic [NUM_SRC-1:0]   o_clr
);

    // Scan from the top down so the lowest-index request overwrites last.
    always_comb begin
        o_id  = '0;
        o_clr = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_id     = IRQC_ID_W'(i + 1);
                o_clr    = '0;
                o_clr[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb2irqc.sv
// AHB-Lite interrupt controller: latches, masks and prioritises peripheral
// interrupt lines and drives the core's irqs vector. Zero wait states.
module ahb2irqc
    import ahb2irqc_pkg::*;
#(
    parameter int NUM_SRC   = 8,
    parameter int IRQ_WIDTH = 32,
    parameter int IRQ_BASE  = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    ahb2irqc_if.slave            ahb,
    input  logic [NUM_SRC-1:0]   src_irq,
    output logic [IRQ_WIDTH-1:0] irqs,
    output logic                 irq_any
);

    logic                 r_selQ;
    logic                 r_writeQ;
    logic [2:0]           r_addrQ;
    logic [NUM_SRC-1:0]   r_pending;
    logic [NUM_SRC-1:0]   r_enable;
    logic [NUM_SRC-1:0]   r_edge;
    logic [NUM_SRC-1:0]   r_srcQ;
    logic [IRQ_WIDTH-1:0] r_irqs;
    logic                 r_irqAny;

    logic                 w_addrValid;
    logic                 w_wrEn;
    logic                 w_rdEn;
    logic [NUM_SRC-1:0]   w_wdata;
    logic [NUM_SRC-1:0]   w_rise;
    logic [NUM_SRC-1:0]   w_w1c;
    logic [NUM_SRC-1:0]   w_set;
    logic [NUM_SRC-1:0]   w_claimClr;
    logic [NUM_SRC-1:0]   w_claimOneHot;
    logic [NUM_SRC-1:0]   w_clr;
    logic [NUM_SRC-1:0]   w_active;
    logic [NUM_SRC-1:0]   w_pendNext;
    logic [IRQC_ID_W-1:0] w_claimId;
    logic [IRQ_WIDTH-1:0] w_irqsNext;
    logic [AHB_DW-1:0]    w_rdata;
    logic                 w_unused;

    assign w_addrValid = isValidXfer(ahb.HSEL, ahb.HREADY, ahb.HTRANS);
    assign w_wrEn      = r_selQ & r_writeQ;
    assign w_rdEn      = r_selQ & ~r_writeQ;
    assign w_wdata     = ahb.HWDATA[NUM_SRC-1:0];
    assign w_rise      = src_irq & ~r_srcQ;
    assign w_active    = r_pending & r_enable;

    assign w_w1c      = (w_wrEn && r_addrQ == IRQC_PENDING) ? w_wdata : '0;
    assign w_set      = (w_wrEn && r_addrQ == IRQC_SET)     ? w_wdata : '0;
    assign w_claimClr = (w_rdEn && r_addrQ == IRQC_CLAIM)   ? w_claimOneHot : '0;
    assign w_clr      = w_w1c | w_claimClr;

    // Edge bits: set and rise win over clear. Level bits follow the line.
    assign w_pendNext = (r_edge & ((r_pending & ~w_clr) | w_rise | w_set))
                      | (~r_edge & src_irq);

    assign w_unused = ^{ahb.HADDR[AHB_DW-1:5], ahb.HADDR[1:0], ahb.HTRANS[0],
                        ahb.HWDATA[AHB_DW-1:NUM_SRC]};

    irqc_prio_enc #(
        .NUM_SRC (NUM_SRC)
    ) u_prioEnc (
        .i_req (w_active),
        .o_id  (w_claimId),
        .o_clr (w_claimOneHot)
    );

    // Capture the address phase so the data phase knows what to do.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_selQ   <= 1'b0;
            r_writeQ <= 1'b0;
            r_addrQ  <= '0;
        end else begin
            r_selQ <= w_addrValid;
            if (w_addrValid) begin
                r_writeQ <= ahb.HWRITE;
                r_addrQ  <= ahb.HADDR[4:2];
            end
        end
    end

    // ENABLE and EDGE are plain read/write registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_enable <= '0;
            r_edge   <= '0;
        end else if (w_wrEn) begin
            if (r_addrQ == IRQC_ENABLE) r_enable <= w_wdata;
            if (r_addrQ == IRQC_EDGE)   r_edge   <= w_wdata;
        end
    end

    // Source history for edge detection and the pending state itself.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_srcQ    <= '0;
            r_pending <= '0;
        end else begin
            r_srcQ    <= src_irq;
            r_pending <= w_pendNext;
        end
    end

    // Place the masked pending bits in their slot of the core vector.
    always_comb begin
        w_irqsNext = '0;
        w_irqsNext[IRQ_BASE +: NUM_SRC] = w_active;
    end

    // Outputs to the core are registered one cycle after pending/enable.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_irqs   <= '0;
            r_irqAny <= 1'b0;
        end else begin
            r_irqs   <= w_irqsNext;
            r_irqAny <= |w_active;
        end
    end

    // Read data mux; everything unmapped or write-only returns zero.
    always_comb begin
        w_rdata = '0;
        if (w_rdEn) begin
            case (r_addrQ)
                IRQC_PENDING: w_rdata = AHB_DW'(r_pending);
                IRQC_ENABLE:  w_rdata = AHB_DW'(r_enable);
                IRQC_EDGE:    w_rdata = AHB_DW'(r_edge);
                IRQC_CLAIM:   w_rdata = AHB_DW'(w_claimId);
                default:      w_rdata = '0;
            endcase
        end
    end

    assign ahb.HRDATA    = w_rdata;
    assign ahb.HREADYOUT = 1'b1;
    assign irqs          = r_irqs;
    assign irq_any       = r_irqAny;

endmodule

// File: tb/tb_ahb2irqc.sv
// Testbench for ahb2irqc: a table of bus/source operations with expected
// results, followed by hand-written multi-cycle sequences.
module tb_ahb2irqc;
    import ahb2irqc_pkg::*;

    localparam int NUM_SRC   = 8;
    localparam int IRQ_WIDTH = 32;
    localparam int IRQ_BASE  = 1;

    typedef enum {OP_WR, OP_RD, OP_SRC, OP_TICK, OP_IRQ, OP_ANY} opE;

    typedef struct {
        opE          op;
        logic [2:0]  regOff;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vecT;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sbT;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [NUM_SRC-1:0]   src_irq;
    logic [IRQ_WIDTH-1:0] irqs;
    logic                 irq_any;

    vecT vecs[$];
    sbT  sbQ[$];
    int  nVec = 0;
    int  nMis = 0;

    ahb2irqc_if ahb();

    ahb2irqc #(
        .NUM_SRC   (NUM_SRC),
        .IRQ_WIDTH (IRQ_WIDTH),
        .IRQ_BASE  (IRQ_BASE)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .ahb     (ahb),
        .src_irq (src_irq),
        .irqs    (irqs),
        .irq_any (irq_any)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic driveIdle();
        ahb.HSEL   = 1'b0;
        ahb.HTRANS = 2'b00;
        ahb.HWRITE = 1'b0;
        ahb.HADDR  = '0;
    endtask

    task automatic addrPhase(input logic wr, input logic [2:0] off);
        ahb.HSEL   = 1'b1;
        ahb.HREADY = 1'b1;
        ahb.HTRANS = 2'b10;
        ahb.HWRITE = wr;
        ahb.HADDR  = {27'd0, off, 2'b00};
    endtask

    task automatic popCheck();
        sbT sb;
        if (sbQ.size() == 0) begin
            nVec++;
            nMis++;
            $display("[TB] FAIL scoreboard: read data with no expectation queued");
        end else begin
            sb = sbQ.pop_front();
            checkOutput(sb.name, ahb.HRDATA, sb.exp);
            checkOutput({sb.name, "_hreadyout"}, 32'(ahb.HREADYOUT), 32'd1);
        end
    endtask

    task automatic busWrite(input logic [2:0] off, input logic [31:0] data);
        addrPhase(1'b1, off);
        tick();
        driveIdle();
        ahb.HWDATA = data;
        tick();
    endtask

    task automatic busRead(input logic [2:0] off, input logic [31:0] exp,
                           input string name);
        addrPhase(1'b0, off);
        sbQ.push_back('{name, exp});
        tick();
        driveIdle();
        popCheck();
        tick();
    endtask

    task automatic addVec(input opE op, input logic [2:0] off, input logic [31:0] data,
                          input logic [31:0] exp, input string name);
        vecs.push_back('{op, off, data, exp, name});
    endtask

    task automatic applyStimulus(input vecT v);
        case (v.op)
            OP_WR:   busWrite(v.regOff, v.data);
            OP_RD:   busRead(v.regOff, v.exp, v.name);
            OP_SRC:  src_irq = v.data[NUM_SRC-1:0];
            OP_TICK: tick();
            OP_IRQ:  checkOutput(v.name, irqs, v.exp);
            OP_ANY:  checkOutput(v.name, 32'(irq_any), v.exp);
            default: ;
        endcase
    endtask

    // Watchdog so a broken run still ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        src_irq    = '0;
        ahb.HREADY = 1'b1;
        ahb.HWDATA = '0;
        driveIdle();
        repeat (3) tick();
        reset = 1'b0;

        // Reset state: every offset reads zero, outputs quiet.
        for (int i = 0; i < 8; i++)
            addVec(OP_RD, 3'(i), 0, 0, $sformatf("reset_rd_off%0d", i));
        addVec(OP_IRQ, 0, 0, 32'h0, "reset_irqs");
        addVec(OP_ANY, 0, 0, 32'h0, "reset_any");

        // Level mode on source 0.
        addVec(OP_WR,   IRQC_ENABLE, 32'h01, 0, "");
        addVec(OP_RD,   IRQC_ENABLE, 0, 32'h01, "lvl_enable_rd");
        addVec(OP_SRC,  0, 32'h01, 0, "");
        addVec(OP_TICK, 0, 0, 0, "");
        addVec(OP_IRQ,  0, 0, 32'h0, "lvl_rise_1cyc");
        addVec(OP_TICK, 0, 0, 0, "");
        addVec(OP_IRQ,  0, 0, 32'h2, "lvl_rise_2cyc");
        addVec(OP_ANY,  0, 0, 32'h1, "lvl_any");
        addVec(OP_SRC,  0, 32'h00, 0, "");
        addVec(OP_TICK, 0, 0, 0, "");
        addVec(OP_IRQ,  0, 0, 32'h2, "lvl_fall_1cyc");
        addVec(OP_TICK, 0, 0, 0, "");
        addVec(OP_IRQ,  0, 0, 32'h0, "lvl_fall_2cyc");
        addVec(OP_SRC,  0, 32'h01, 0, "");
        addVec(OP_TICK, 0, 0, 0, "");
        addVec(OP_TICK, 0, 0, 0, "");
        addVec(OP_WR,   IRQC_PENDING, 32'h01, 0, "");
        addVec(OP_RD,   IRQC_PENDING, 0, 32'h01, "lvl_w1c_ignored");
        addVec(OP_IRQ,  0, 0, 32'h2, "lvl_w1c_irqs");
        addVec(OP_SRC,  0, 32'h00, 0, "");
        addVec(OP_TICK, 0, 0, 0, "");
        addVec(OP_TICK, 0, 0, 0, "");
        addVec(OP_RD,   IRQC_PENDING, 0, 32'h00, "lvl_drop_pending");
        addVec(OP_WR,   IRQC_ENABLE, 32'h00, 0, "");

        // Edge mode on source 6.
        addVec(OP_WR,   IRQC_EDGE,   32'h40, 0, "");
        addVec(OP_WR,   IRQC_ENABLE, 32'h40, 0, "");
        addVec(OP_RD,   IRQC_EDGE,   0, 32'h40, "edge_edge_rd");
        addVec(OP_SRC,  0, 32'h40, 0, "");
        addVec(OP_TICK, 0, 0, 0, "");
        addVec(OP_SRC,  0, 32'h00, 0, "");
        addVec(OP_TICK, 0, 0, 0, "");
        addVec(OP_RD,   IRQC_PENDING, 0, 32'h40, "edge_pending");
        addVec(OP_IRQ,  0, 0, 32'h80, "edge_irqs");
        addVec(OP_TICK, 0, 0, 0, "");
        addVec(OP_TICK, 0, 0, 0, "");
        addVec(OP_IRQ,  0, 0, 32'h80, "edge_irqs_held");
        addVec(OP_RD,   IRQC_CLAIM, 0, 32'd7, "edge_claim");
        addVec(OP_RD,   IRQC_PENDING, 0, 32'h00, "edge_after_claim");
        addVec(OP_IRQ,  0, 0, 32'h0, "edge_irqs_cleared");

        // Priority among several edge sources, one of them disabled.
        addVec(OP_WR,   IRQC_EDGE,   32'hFF, 0, "");
        addVec(OP_WR,   IRQC_ENABLE, 32'h0A, 0, "");
        addVec(OP_WR,   IRQC_SET,    32'h0E, 0, "");
        addVec(OP_TICK, 0, 0, 0, "");
        addVec(OP_IRQ,  0, 0, 32'h14, "prio_irqs");
        addVec(OP_ANY,  0, 0, 32'h1, "prio_any");
        addVec(OP_RD,   IRQC_CLAIM, 0, 32'd2, "prio_claim1");
        addVec(OP_RD,   IRQC_CLAIM, 0, 32'd4, "prio_claim2");
        addVec(OP_RD,   IRQC_CLAIM, 0, 32'd0, "prio_claim3");
        addVec(OP_RD,   IRQC_PENDING, 0, 32'h04, "prio_pending");
        addVec(OP_RD,   IRQC_SET, 0, 32'h00, "set_reads_zero");
        addVec(OP_WR,   IRQC_PENDING, 32'h04, 0, "");
        addVec(OP_RD,   IRQC_PENDING, 0, 32'h00, "prio_w1c");
        addVec(OP_ANY,  0, 0, 32'h0, "prio_any_idle");

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Collision: W1C and a rising edge on the same bit in one cycle.
        addrPhase(1'b1, IRQC_PENDING);
        tick();
        driveIdle();
        ahb.HWDATA = 32'h01;
        src_irq    = 8'h01;
        tick();
        src_irq = 8'h00;
        busRead(IRQC_PENDING, 32'h01, "collision_pending");
        busWrite(IRQC_PENDING, 32'h01);
        busRead(IRQC_PENDING, 32'h00, "collision_w1c");

        // A rise during a CLAIM data phase is not claimed and stays pending.
        busWrite(IRQC_ENABLE, 32'h0B);
        busWrite(IRQC_SET, 32'h02);
        addrPhase(1'b0, IRQC_CLAIM);
        sbQ.push_back('{"claim_rise_claim", 32'd2});
        tick();
        driveIdle();
        src_irq = 8'h01;
        popCheck();
        tick();
        src_irq = 8'h00;
        busRead(IRQC_PENDING, 32'h01, "claim_rise_pending");
        busRead(IRQC_CLAIM, 32'd1, "claim_rise_claim2");
        busRead(IRQC_PENDING, 32'h00, "claim_rise_done");

        // IDLE transfer and HREADY low must not write.
        busWrite(IRQC_ENABLE, 32'h00);
        ahb.HSEL   = 1'b1;
        ahb.HTRANS = 2'b00;
        ahb.HWRITE = 1'b1;
        ahb.HADDR  = {27'd0, IRQC_ENABLE, 2'b00};
        tick();
        driveIdle();
        ahb.HWDATA = 32'hFF;
        tick();
        busRead(IRQC_ENABLE, 32'h00, "idle_no_write");
        addrPhase(1'b1, IRQC_ENABLE);
        ahb.HREADY = 1'b0;
        tick();
        ahb.HREADY = 1'b1;
        driveIdle();
        ahb.HWDATA = 32'hFF;
        tick();
        busRead(IRQC_ENABLE, 32'h00, "hready_low_no_write");

        // Unmapped offset write changes nothing.
        busWrite(3'd6, 32'hFF);
        busRead(IRQC_PENDING, 32'h00, "unmapped_pending");
        busRead(IRQC_ENABLE,  32'h00, "unmapped_enable");
        busRead(IRQC_EDGE,    32'hFF, "unmapped_edge");
        busRead(3'd6,         32'h00, "unmapped_rd");

        // Back-to-back: write ENABLE then read it in the overlapped phase.
        addrPhase(1'b1, IRQC_ENABLE);
        tick();
        ahb.HWDATA = 32'h05;
        addrPhase(1'b0, IRQC_ENABLE);
        sbQ.push_back('{"b2b_enable", 32'h05});
        tick();
        driveIdle();
        popCheck();
        tick();

        // Reset during a write data phase drops the write.
        addrPhase(1'b1, IRQC_ENABLE);
        tick();
        driveIdle();
        ahb.HWDATA = 32'hFF;
        reset      = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        busRead(IRQC_ENABLE, 32'h00, "reset_mid_enable");
        busRead(IRQC_EDGE,   32'h00, "reset_mid_edge");
        checkOutput("reset_mid_irqs", irqs, 32'h0);

        if (sbQ.size() != 0) begin
            nVec++;
            nMis++;
            $display("[TB] FAIL scoreboard_leftover: %0d entries, expected 0", sbQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/ahb2irqc.md
Name: ahb2irqc

Overview:
- AHB-Lite slave interrupt controller on the data bus, decoded as a free slave slot of the platform address decoder.
- Downstream of the peripheral IRQ lines (timer, UART, NI): it latches them, masks them and prioritises them.
- Upstream of the core: it drives the core's 32-bit irqs vector.
- Zero-wait-state register interface; all state updates on the rising edge of clock.

Parameters:
NUM_SRC, 8, number of interrupt sources (1..31)
IRQ_WIDTH, 32, width of the core irqs vector
IRQ_BASE, 1, irqs bit index driven by source 0; IRQ_BASE+NUM_SRC <= IRQ_WIDTH

Ports:
clock  in  1  single system clock
reset  in  1  synchronous, active-high reset
HSEL  in  1  slave select from the address decoder
HREADY  in  1  bus ready (address phase valid when 1)
HADDR  in  32  address; only [4:2] decoded
HTRANS  in  2  transfer type; bit 1 set = NONSEQ/SEQ
HWRITE  in  1  write when 1
HWDATA  in  32  write data (data phase)
HRDATA  out  32  read data (data phase)
HREADYOUT  out  1  always 1
src_irq  in  NUM_SRC  peripheral interrupt lines, same clock domain
irqs  out  IRQ_WIDTH  interrupt vector to the core
irq_any  out  1  OR of all enabled pending sources

Behaviour:
- Reset (sync, reset=1 at a clock edge): PENDING, ENABLE, EDGE, src_q, irqs, irq_any, and the address-phase registers are all 0. HRDATA is 0; HREADYOUT is 1.
- Address phase: when HSEL & HREADY & HTRANS[1], capture sel_q=1, write_q=HWRITE, addr_q=HADDR[4:2]. Otherwise sel_q=0.
- Data phase (cycle after capture), when sel_q=1:
  - write_q=1: write uses HWDATA[NUM_SRC-1:0].
  - write_q=0: HRDATA is driven combinationally from the registers selected by addr_q.
  - HRDATA is 0 when sel_q=0.
- Register map (word offsets):
  - 0x00 PENDING: read; write-1-to-clear, edge-mode bits only.
  - 0x04 ENABLE: read/write.
  - 0x08 EDGE: read/write; 1 = rising-edge latched, 0 = level.
  - 0x0C CLAIM: read-only. Returns ID+1 of the lowest-index source with PENDING&ENABLE, or 0 if none. The read clears that source's pending bit if it is edge-mode.
  - 0x10 SET: write-only; write-1 sets pending for edge-mode bits; reads return 0.
  - Offsets 0x14–0x1C: read 0, writes ignored. Upper unused register bits read 0. HSIZE is not decoded; all accesses are treated as words.
- Edge detect: src_q <= src_irq each cycle; rise = src_irq & ~src_q.
- Pending next-state, per bit i:
  - Level mode: pending = src_irq[i], live and registered each cycle. W1C, SET and CLAIM have no effect.
  - Edge mode: pending <= (pending & ~clr) | rise | set. Set wins over clear in the same cycle.
  - EDGE write switching a bit to level: pending takes src_irq on the next cycle.
- Outputs, registered with one cycle latency from the pending/enable update:
  - irqs[IRQ_BASE+i] <= PENDING[i] & ENABLE[i].
  - irqs bits outside [IRQ_BASE, IRQ_BASE+NUM_SRC-1] stay 0.
  - irq_any <= |(PENDING & ENABLE).
- CLAIM priority and side effects:
  - Fixed priority, lowest index first.
  - Disabled pending sources are never returned.
  - The CLAIM value is computed from pending at the start of the data phase. A rise arriving in the same cycle stays pending.
- Back-to-back transfers: the address phase of transfer N+1 overlaps the data phase of N. A write to ENABLE in N is visible to a read in N+1.
- Reset mid-transfer: the pending data phase is dropped and no register is written.

Decomposition:
- Shared package: register offset constants (IRQC_PENDING=3'd0, ENABLE=3'd1, EDGE=3'd2, CLAIM=3'd3, SET=3'd4).
- One natural sub-module, irqc_prio_enc: combinational lowest-index encoder over NUM_SRC bits. Outputs the ID+1 and a one-hot clear vector.

Test Plan:
- Reset, then read all offsets: every read returns 0; irqs=0; HREADYOUT=1 throughout.
- Level mode:
  - Write ENABLE=0x01, raise src_irq[0] → irqs[1]=1 exactly 2 cycles later.
  - Drop src_irq[0] → irqs[1]=0 2 cycles later.
  - W1C PENDING=0x01 while the source is high → bit stays 1.
- Edge mode:
  - Write EDGE=0x40, ENABLE=0x40, pulse src_irq[6] for 1 cycle → PENDING reads 0x40 and irqs[7]=1 stays high.
  - Read CLAIM → returns 7; next PENDING read returns 0.
- Priority: EDGE=0xFF, ENABLE=0x0A, SET=0x0E.
  - CLAIM reads return 2, then 4, then 0.
  - PENDING then reads 0x04, because bit 2 is disabled and is never claimed.
- Collision: in the same cycle, W1C PENDING=0x01 and a rising edge on src_irq[0] (edge mode) → PENDING reads 0x01.
- Bus protocol:
  - IDLE transfer (HTRANS=0) with HSEL=1 writing 0xFF to ENABLE → ENABLE stays 0.
  - Write to offset 0x18 → no register changes.
  - Assert reset during a write data phase → ENABLE=0 afterwards.
